// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the raw PS/2 lines,
// deframes 11-bit frames and presents the last two good bytes as a 16-bit keycode.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        keycode_valid,
  output logic        frame_err,
  output logic [1:0]  fsm_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          fclk_prev_q;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   kc_q, kc_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          fall;
  logic          data_bit;
  logic          timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      fclk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q     <= {ps2_data, ps2_clk};
      sync2_q     <= sync1_q;
      fclk_prev_q <= filt_q[0];
      // The filtered copy follows only a level held for FILTER_LEN cycles in a row.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall        = fclk_prev_q & ~filt_q[0];
  assign data_bit    = filt_q[1];
  assign timeout_hit = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      kc_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
      kc_q      <= kc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_d      = to_q;
    kc_d      = kc_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_bit;
          state_d = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          // Good frame: stop bit high and odd count of ones over data plus parity.
          if (data_bit && (^{shift_q, par_q})) begin
            kc_d    = {kc_q[7:0], shift_q};
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      to_d      = '0;
      err_d     = 1'b1;
    end else if (state_q != IDLE) begin
      if (to_q != TW'(TIMEOUT_CYCLES)) to_d = to_q + 1'b1;
    end else begin
      to_d = '0;
    end
  end

  assign keycode       = kc_q;
  assign keycode_valid = valid_q;
  assign frame_err     = err_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frames are driven bit by bit, a frame-level
// model predicts each valid/error pulse, and a per-cycle compare process checks them.
module tb_ps2_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int HALF           = 40;   // PS/2 half bit period in clk cycles (scaled down)

  logic        clk;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Expected event queue: bit 16 = error pulse, [15:0] = keycode required at that pulse.
  logic [16:0] exp_q[$];
  logic [15:0] pk;
  logic [15:0] last_kc;

  ps2_receiver #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keycode(keycode),
    .keycode_valid(keycode_valid),
    .frame_err(frame_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      last_kc = 16'h0000;
    end else begin
      checks++;
      if (keycode_valid && frame_err) begin
        errors++;
        $display("FAIL both_pulses: valid=%b err=%b, expected never both", keycode_valid, frame_err);
      end
      if (keycode_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (keycode_valid || frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=%b err=%b keycode=%h, expected no pulse",
                   keycode_valid, frame_err, keycode);
        end else begin
          e = exp_q.pop_front();
          if (frame_err !== e[16] || keycode !== e[15:0]) begin
            errors++;
            $display("FAIL event: err=%b keycode=%h, expected err=%b keycode=%h",
                     frame_err, keycode, e[16], e[15:0]);
          end
          last_kc = e[15:0];
        end
      end else if (keycode !== last_kc) begin
        errors++;
        $display("FAIL keycode_hold: got %h, expected %h", keycode, last_kc);
      end
    end
  end

  // driver tasks
  task automatic send_raw(input logic [10:0] bits, input int n_edges, input int glitch_at);
    for (int i = 0; i < n_edges; i++) begin
      ps2_data = bits[i];
      if (i == glitch_at) begin
        tick(10);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(HALF - 13);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(20);
    check(name, exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int glitch_at, input string name);
    int ones;
    ones = $countones({b, par});
    if (stop && (ones % 2 == 1)) begin
      pk = {pk[7:0], b};
      exp_q.push_back({1'b0, pk});
    end else begin
      exp_q.push_back({1'b1, pk});
    end
    send_raw({stop, par, b, 1'b0}, 11, glitch_at);
    wait_drain(name);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    pk       = 16'h0000;
    last_kc  = 16'h0000;
    tick(3);
    @(negedge clk);
    check("reset_keycode", keycode, 16'h0000);
    check("reset_valid", keycode_valid, 0);
    check("reset_err", frame_err, 0);
    check("reset_state", fsm_state, 0);
    tick(1);
    rst = 1'b0;
    tick(20);

    send_frame(8'h1C, 1'b0, 1'b1, -1, "drain_1c");
    check("lit_001c", keycode, 16'h001C);
    send_frame(8'hF0, 1'b1, 1'b1, -1, "drain_f0");
    check("lit_1cf0", keycode, 16'h1CF0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, "drain_1c_b");
    check("lit_f01c", keycode, 16'hF01C);

    send_frame(8'h1C, 1'b1, 1'b1, -1, "drain_bad_parity");
    send_frame(8'h1C, 1'b0, 1'b0, -1, "drain_bad_stop");
    check("lit_after_bad", keycode, 16'hF01C);

    exp_q.push_back({1'b1, pk});
    send_raw(11'h7FF, 1, -1);
    wait_drain("drain_bad_start");

    // Start bit plus four data bits, then silence until the timeout fires.
    exp_q.push_back({1'b1, pk});
    send_raw({1'b1, 1'b0, 8'h29, 1'b0}, 5, -1);
    tick(TIMEOUT_CYCLES + 10);
    wait_drain("drain_timeout");
    send_frame(8'h29, 1'b0, 1'b1, -1, "drain_29");
    check("lit_29", keycode, 16'h1C29);

    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    send_frame(8'h1C, 1'b0, 1'b1, 4, "drain_glitch");
    check("lit_glitch", keycode, 16'h291C);

    // Partial frame cut short by a one-cycle reset, then a clean frame.
    send_raw({1'b1, 1'b1, 8'h5A, 1'b0}, 6, -1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pk = 16'h0000;
    tick(30);
    send_frame(8'h5A, 1'b1, 1'b1, -1, "drain_5a");
    check("lit_005a", keycode, 16'h005A);

    check("total_valid", valid_cnt, 6);
    check("total_err", err_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
